// File: rtl/video_timing_pkg.sv
// Shared video timing constants (1080p60) and colour-bar palette, used by
// both the TX timing generator and the HDMI input path.
package video_timing_pkg;

  localparam logic [11:0] VT_H_TOTAL   = 12'd2200;
  localparam logic [11:0] VT_H_SYNC    = 12'd44;
  localparam logic [11:0] VT_H_BP      = 12'd148;
  localparam logic [11:0] VT_H_ACT     = 12'd1920;
  localparam logic [11:0] VT_V_TOTAL   = 12'd1125;
  localparam logic [11:0] VT_V_SYNC    = 12'd5;
  localparam logic [11:0] VT_V_BP      = 12'd36;
  localparam logic [11:0] VT_V_ACT     = 12'd1080;
  localparam logic [11:0] VT_HV_OFFSET = 12'd0;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [2:0] {
    BAR_WHITE,
    BAR_YELLOW,
    BAR_CYAN,
    BAR_GREEN,
    BAR_MAGENTA,
    BAR_RED,
    BAR_BLUE,
    BAR_BLACK
  } bar_e;

  function automatic rgb_t bar_color(input bar_e bar);
    rgb_t c;
    c = '0;
    case (bar)
      BAR_WHITE:   c = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
      BAR_YELLOW:  c = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
      BAR_CYAN:    c = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
      BAR_GREEN:   c = '{r: 8'h00, g: 8'hFF, b: 8'h00};
      BAR_MAGENTA: c = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
      BAR_RED:     c = '{r: 8'hFF, g: 8'h00, b: 8'h00};
      BAR_BLUE:    c = '{r: 8'h00, g: 8'h00, b: 8'hFF};
      default:     c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_gen_color_bar_gen.sv
// Eight vertical colour bars; the bar index advances by counting pixels
// within the current bar, so no divider is needed.
module color_bar_gen
  import video_timing_pkg::*;
#(
  parameter logic [11:0] SEG_LEN = VT_H_ACT >> 3
) (
  input  logic        pix_clk,
  input  logic        rst,
  input  logic [11:0] x_act,
  input  logic        pix_req,
  output logic [23:0] rgb
);

  bar_e        idx;
  bar_e        idx_next;
  logic [11:0] cnt;
  logic [11:0] cnt_next;

  always_comb begin
    idx_next = idx;
    cnt_next = cnt + 12'd1;
    if (x_act == '0) begin
      idx_next = BAR_WHITE;
      cnt_next = 12'd1;
    end else if (cnt == SEG_LEN) begin
      idx_next = (idx == BAR_BLACK) ? BAR_BLACK : bar_e'(idx + 3'd1);
      cnt_next = 12'd1;
    end
  end

  // rgb is registered so it lines up with de_out one cycle after the request
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      idx <= BAR_WHITE;
      cnt <= '0;
      rgb <= '0;
    end else begin
      rgb <= '0;
      if (pix_req) begin
        idx <= idx_next;
        cnt <= cnt_next;
        rgb <= bar_color(idx_next);
      end
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator: raw h/v timing, a request stage for upstream pixel
// fetch, and an output stage aligned with the returned pixel data.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter logic [11:0] H_TOTAL   = VT_H_TOTAL,
  parameter logic [11:0] H_SYNC    = VT_H_SYNC,
  parameter logic [11:0] H_BP      = VT_H_BP,
  parameter logic [11:0] H_ACT     = VT_H_ACT,
  parameter logic [11:0] V_TOTAL   = VT_V_TOTAL,
  parameter logic [11:0] V_SYNC    = VT_V_SYNC,
  parameter logic [11:0] V_BP      = VT_V_BP,
  parameter logic [11:0] V_ACT     = VT_V_ACT,
  parameter logic [11:0] HV_OFFSET = VT_HV_OFFSET
) (
  input  logic        pix_clk,
  input  logic        rst,
  input  logic        en,
  input  logic        pattern_en,
  output logic        pix_req,
  output logic [11:0] x_act,
  output logic [11:0] y_act,
  input  logic [7:0]  r_in,
  input  logic [7:0]  g_in,
  input  logic [7:0]  b_in,
  output logic        vs_out,
  output logic        hs_out,
  output logic        de_out,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic        frame_start
);

  localparam logic [11:0] H_START = H_SYNC + H_BP;
  localparam logic [11:0] H_END   = H_START + H_ACT;
  localparam logic [11:0] V_START = V_SYNC + V_BP;
  localparam logic [11:0] V_END   = V_START + V_ACT;

  logic        clr;
  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        hs_raw;
  logic        vs_raw;
  logic        de_raw;
  logic        hs_s1;
  logic        vs_s1;
  logic        pattern_q;
  logic [23:0] bar_rgb;

  assign clr = rst | ~en;

  always_ff @(posedge pix_clk) begin
    if (clr) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_TOTAL - 12'd1) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_TOTAL - 12'd1) ? '0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // vs expressed as a level: set at (0, HV_OFFSET), cleared at (V_SYNC, HV_OFFSET)
  always_comb begin
    hs_raw = (h_cnt < H_SYNC);
    de_raw = (h_cnt >= H_START) && (h_cnt < H_END) &&
             (v_cnt >= V_START) && (v_cnt < V_END);
    vs_raw = ((v_cnt == '0) && (h_cnt >= HV_OFFSET)) ||
             ((v_cnt != '0) && (v_cnt < V_SYNC)) ||
             ((v_cnt == V_SYNC) && (h_cnt < HV_OFFSET));
  end

  always_ff @(posedge pix_clk) begin
    if (clr) begin
      pix_req <= 1'b0;
      x_act   <= '0;
      y_act   <= '0;
      hs_s1   <= 1'b0;
      vs_s1   <= 1'b0;
    end else begin
      pix_req <= de_raw;
      x_act   <= de_raw ? h_cnt - H_START : '0;
      y_act   <= de_raw ? v_cnt - V_START : '0;
      hs_s1   <= hs_raw;
      vs_s1   <= vs_raw;
    end
  end

  always_ff @(posedge pix_clk) begin
    if (clr) begin
      hs_out      <= 1'b0;
      vs_out      <= 1'b0;
      de_out      <= 1'b0;
      pattern_q   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hs_out      <= hs_s1;
      vs_out      <= vs_s1;
      de_out      <= pix_req;
      pattern_q   <= pattern_en;
      frame_start <= pix_req && (x_act == '0) && (y_act == '0);
    end
  end

  color_bar_gen #(
    .SEG_LEN (H_ACT >> 3)
  ) u_color_bar_gen (
    .pix_clk (pix_clk),
    .rst     (clr),
    .x_act   (x_act),
    .pix_req (pix_req),
    .rgb     (bar_rgb)
  );

  // upstream data arrives in the de_out cycle, so it is muxed straight through
  always_comb begin
    {r_out, g_out, b_out} = '0;
    if (de_out) begin
      {r_out, g_out, b_out} = pattern_q ? bar_rgb : {r_in, g_in, b_in};
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: reduced-timing instance checked cycle by cycle against a
// positional model, plus a 1080p-width instance for colour-bar boundaries.
module tb_video_timing_gen;

  logic        pix_clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_a = 1'b0;
  logic        en_b = 1'b0;
  logic        pat_a = 1'b0;
  logic        pat_b = 1'b1;
  logic [7:0]  r_in = '0;
  logic [7:0]  g_in = '0;
  logic [7:0]  b_in = '0;

  logic        pix_req_a, hs_a, vs_a, de_a, fs_a;
  logic [11:0] x_act_a, y_act_a;
  logic [7:0]  r_a, g_a, b_a;
  logic        pix_req_b, hs_b, vs_b, de_b, fs_b;
  logic [11:0] x_act_b, y_act_b;
  logic [7:0]  r_b, g_b, b_b;

  int asserts = 0;
  int fails = 0;
  int n_a = 0;
  int de_cnt, hs_cnt, vs_cnt, fs_cnt, first_req, first_vs;

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  always #5 pix_clk = ~pix_clk;

  video_timing_gen #(
    .H_TOTAL(12'd20), .H_SYNC(12'd2), .H_BP(12'd3), .H_ACT(12'd8),
    .V_TOTAL(12'd10), .V_SYNC(12'd1), .V_BP(12'd2), .V_ACT(12'd4),
    .HV_OFFSET(12'd7)
  ) dut_a (
    .pix_clk(pix_clk), .rst(rst), .en(en_a), .pattern_en(pat_a),
    .pix_req(pix_req_a), .x_act(x_act_a), .y_act(y_act_a),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .vs_out(vs_a), .hs_out(hs_a), .de_out(de_a),
    .r_out(r_a), .g_out(g_a), .b_out(b_a), .frame_start(fs_a)
  );

  video_timing_gen #(
    .V_TOTAL(12'd10), .V_SYNC(12'd1), .V_BP(12'd2), .V_ACT(12'd4)
  ) dut_b (
    .pix_clk(pix_clk), .rst(rst), .en(en_b), .pattern_en(pat_b),
    .pix_req(pix_req_b), .x_act(x_act_b), .y_act(y_act_b),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .vs_out(vs_b), .hs_out(hs_b), .de_out(de_b),
    .r_out(r_b), .g_out(g_b), .b_out(b_b), .frame_start(fs_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // raw timing of position p counted from the first enabled edge:
  // {req, x, y, hs, vs}
  function automatic logic [26:0] raw(input int p);
    int h, v;
    logic req;
    if (p < 0) return '0;
    h = p % 20;
    v = (p / 20) % 10;
    req = (h >= 5) && (h < 13) && (v >= 3) && (v < 7);
    return {req, req ? 12'(h - 5) : 12'd0, req ? 12'(v - 3) : 12'd0,
            (h < 2), ((v == 0) && (h >= 7)) || ((v == 1) && (h < 7))};
  endfunction

  function automatic logic [63:0] model_a(input int n, input logic pat);
    logic [26:0] r1, r2;
    logic [11:0] x2, y2;
    logic        de2;
    logic [23:0] rgb;
    r1 = raw(n - 1);
    r2 = raw(n - 2);
    de2 = r2[26];
    x2 = r2[25:14];
    y2 = r2[13:2];
    rgb = de2 ? (pat ? BARS[x2[2:0]] : {x2[7:0], y2[7:0], 8'hA5}) : 24'h0;
    return {11'd0, r1[26:2], r2[1], r2[0], de2, de2 && (x2 == 0) && (y2 == 0), rgb};
  endfunction

  function automatic logic [63:0] obs_a();
    return {11'd0, pix_req_a, x_act_a, y_act_a, hs_a, vs_a, de_a, fs_a, r_a, g_a, b_a};
  endfunction

  // one clock; upstream answers the request seen in the closing cycle
  task automatic tick();
    logic        rq;
    logic [11:0] xq, yq;
    rq = pix_req_a;
    xq = x_act_a;
    yq = y_act_a;
    @(posedge pix_clk);
    if (en_a && !rst) n_a++; else n_a = 0;
    r_in = rq ? xq[7:0] : 8'($urandom);
    g_in = rq ? yq[7:0] : 8'($urandom);
    b_in = rq ? 8'hA5 : 8'($urandom);
    @(negedge pix_clk);
  endtask

  task automatic clear_stats();
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; first_req = -1; first_vs = -1;
  endtask

  task automatic run_a(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      tick();
      check(tag, obs_a(), model_a(n_a, pat_a));
      if (de_a) de_cnt++;
      if (hs_a) hs_cnt++;
      if (vs_a) vs_cnt++;
      if (fs_a) fs_cnt++;
      if (pix_req_a && first_req < 0) first_req = n_a - 1;
      if (vs_a && first_vs < 0) first_vs = n_a - 2;
    end
  endtask

  initial begin
    int  xb;
    bit  done;
    @(negedge pix_clk);

    // reset has priority over en
    rst = 1'b1; en_a = 1'b1;
    run_a(3, "reset_a");
    check("reset_b", {x_act_b, y_act_b, pix_req_b, hs_b, vs_b, de_b, fs_b, r_b, g_b, b_b}, '0);
    rst = 1'b0; en_a = 1'b0;
    run_a(2, "idle_a");

    // two frames, upstream pixels then colour bars mid-frame
    en_a = 1'b1;
    clear_stats();
    run_a(250, "frame_up");
    pat_a = 1'b1;
    run_a(150, "frame_bar");
    check("first_req_pos", 64'(first_req), 64'd65);
    check("first_vs_pos", 64'(first_vs), 64'd7);
    check("de_count", 64'(de_cnt), 64'd64);
    check("hs_count", 64'(hs_cnt), 64'd40);
    check("vs_count", 64'(vs_cnt), 64'd40);
    check("fs_count", 64'(fs_cnt), 64'd2);

    // drop en at v_cnt=5, then restart from vsync
    pat_a = 1'b0;
    run_a(103, "pre_drop");
    en_a = 1'b0;
    run_a(3, "en_drop");
    en_a = 1'b1;
    clear_stats();
    run_a(200, "restart");
    check("restart_first_req", 64'(first_req), 64'd65);
    check("restart_fs_count", 64'(fs_cnt), 64'd1);

    // reset mid-line with en held high
    run_a(47, "pre_rst");
    rst = 1'b1;
    run_a(2, "mid_rst");
    rst = 1'b0;
    clear_stats();
    run_a(200, "post_rst");
    check("post_rst_first_req", 64'(first_req), 64'd65);
    check("post_rst_de_count", 64'(de_cnt), 64'd32);
    check("post_rst_hs_count", 64'(hs_cnt), 64'd20);
    check("post_rst_vs_count", 64'(vs_cnt), 64'd20);
    check("post_rst_fs_count", 64'(fs_cnt), 64'd1);

    // 1080p line width: bar boundaries every 240 pixels
    en_a = 1'b0;
    en_b = 1'b1;
    xb = 0;
    done = 1'b0;
    for (int i = 0; i < 9000 && !done; i++) begin
      tick();
      if (de_b) begin
        check("bar_b", 64'({r_b, g_b, b_b}), 64'((xb < 1920) ? BARS[xb / 240] : 24'h0));
        xb++;
      end else begin
        check("blank_b", 64'({r_b, g_b, b_b}), 64'd0);
        if (xb != 0) done = 1'b1;
      end
    end
    check("bar_line_len", 64'(xb), 64'd1920);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
